// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller bridging pipeline requests to a single-port word RAM
module lsu_ctrl #(
    parameter int DATA_WIDTH = 64,
    parameter int RAM_SIZE   = 12,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_memwid_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic [1:0]            resp_err_o,
    output logic [RAM_SIZE-1:0]   ram_addr_o,
    output logic [1:0]            ram_access_mode_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic [2:0]            ram_memwid_o,
    input  logic [DATA_WIDTH-1:0] ram_data_i,
    input  logic                  ram_illegal_i
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_READ  = 2'd1;
    localparam logic [1:0] MODE_WRITE = 2'd2;
    state_t state, state_n;
    logic       is_load;
    logic       accept;
    logic       handshake;
    logic [1:0] chk_err;
    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign handshake   = resp_valid_o && resp_ready_i;
    // request legality, highest-priority failure wins: width/op, then alignment, then range
    always_comb begin
        chk_err = (req_memwid_i == 3'b111 || (req_we_i && req_memwid_i[2])) ? 2'd3 :
                  (|req_addr_i[2:0])                                        ? 2'd1 :
                  (|req_addr_i[ADDR_WIDTH-1:RAM_SIZE+3])                    ? 2'd2 : 2'd0;
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next-state: rejected requests skip the RAM and respond straight away
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ((chk_err != 2'd0) ? RESP : ISSUE) : IDLE;
            ISSUE:   state_n = CAPTURE;
            CAPTURE: state_n = RESP;
            RESP:    state_n = handshake ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    // datapath: RAM command registered at accept, response built in CAPTURE and held through RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid_o      <= 1'b0;
            resp_rdata_o      <= '0;
            resp_err_o        <= 2'd0;
            ram_addr_o        <= '0;
            ram_access_mode_o <= MODE_NONE;
            ram_data_o        <= '0;
            ram_memwid_o      <= 3'd0;
            is_load           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    resp_err_o   <= chk_err;
                    resp_rdata_o <= '0;
                    is_load      <= !req_we_i;
                    resp_valid_o <= (chk_err != 2'd0);
                    if (chk_err == 2'd0) begin
                        ram_addr_o        <= req_addr_i[RAM_SIZE+2:3];
                        ram_memwid_o      <= req_memwid_i;
                        ram_data_o        <= req_wdata_i;
                        ram_access_mode_o <= req_we_i ? MODE_WRITE : MODE_READ;
                    end
                end
                ISSUE: begin
                    ram_access_mode_o <= MODE_NONE;
                    if (ram_illegal_i) resp_err_o <= 2'd3;
                end
                CAPTURE: begin
                    resp_rdata_o <= (is_load && resp_err_o == 2'd0) ? ram_data_i : '0;
                    resp_valid_o <= 1'b1;
                end
                RESP: if (resp_ready_i) resp_valid_o <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a behavioural extending RAM
module tb_lsu_ctrl;
    logic        clk = 0;
    logic        rst = 1;
    logic        req_valid_i = 0;
    logic        req_ready_o;
    logic        req_we_i = 0;
    logic [63:0] req_addr_i = 0;
    logic [63:0] req_wdata_i = 0;
    logic [2:0]  req_memwid_i = 0;
    logic        resp_valid_o;
    logic        resp_ready_i = 0;
    logic [63:0] resp_rdata_o;
    logic [1:0]  resp_err_o;
    logic [11:0] ram_addr_o;
    logic [1:0]  ram_access_mode_o;
    logic [63:0] ram_data_o;
    logic [2:0]  ram_memwid_o;
    logic [63:0] ram_data_i = 0;
    logic        ram_illegal_i = 0;
    int n_vec = 0;
    int n_err = 0;
    logic [63:0] mem [4096];

    lsu_ctrl #(.DATA_WIDTH(64), .RAM_SIZE(12), .ADDR_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_memwid_i(req_memwid_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .ram_addr_o(ram_addr_o), .ram_access_mode_o(ram_access_mode_o),
        .ram_data_o(ram_data_o), .ram_memwid_o(ram_memwid_o),
        .ram_data_i(ram_data_i), .ram_illegal_i(ram_illegal_i)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wmask(input logic [2:0] w);
        case (w[1:0])
            2'd0:    return 64'hFF;
            2'd1:    return 64'hFFFF;
            2'd2:    return 64'hFFFF_FFFF;
            default: return '1;
        endcase
    endfunction

    function automatic logic [63:0] ext(input logic [63:0] d, input logic [2:0] w);
        case (w)
            3'd0:    return {{56{d[7]}}, d[7:0]};
            3'd1:    return {{48{d[15]}}, d[15:0]};
            3'd2:    return {{32{d[31]}}, d[31:0]};
            3'd4:    return {56'd0, d[7:0]};
            3'd5:    return {48'd0, d[15:0]};
            3'd6:    return {32'd0, d[31:0]};
            default: return d;
        endcase
    endfunction

    // RAM model: write merges low bytes, read returns extended data one edge later
    always @(posedge clk) begin
        if (ram_access_mode_o == 2'd2)
            mem[ram_addr_o] <= (mem[ram_addr_o] & ~wmask(ram_memwid_o)) | (ram_data_o & wmask(ram_memwid_o));
        else if (ram_access_mode_o == 2'd1)
            ram_data_i <= ext(mem[ram_addr_o], ram_memwid_o);
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, required done");
        $fatal(1);
    end

    int          lat;
    int          acc;
    logic [1:0]  mode_seen;
    logic [11:0] addr_seen;

    task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wd, input logic [2:0] wid);
        for (int i = 0; i < 20 && !req_ready_o; i++) @(negedge clk);
        req_valid_i = 1; req_we_i = we; req_addr_i = addr; req_wdata_i = wd; req_memwid_i = wid;
        @(negedge clk);
        req_valid_i = 0;
        lat = 1; acc = 0; mode_seen = 0; addr_seen = 0;
        while (resp_valid_o !== 1'b1 && lat < 10) begin
            if (ram_access_mode_o != 2'd0) begin
                acc++; mode_seen = ram_access_mode_o; addr_seen = ram_addr_o;
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_resp();
        resp_ready_i = 1;
        @(negedge clk);
        resp_ready_i = 0;
    endtask

    task automatic test_reset();
        req_valid_i = 1;
        @(negedge clk);
        n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got %0b want 0", resp_valid_o); end
        n_vec++; if (resp_rdata_o !== 64'd0) begin n_err++; $display("FAIL rst_rdata got %h want 0", resp_rdata_o); end
        n_vec++; if (resp_err_o !== 2'd0) begin n_err++; $display("FAIL rst_err got %0d want 0", resp_err_o); end
        n_vec++; if (ram_access_mode_o !== 2'd0) begin n_err++; $display("FAIL rst_mode got %0d want 0", ram_access_mode_o); end
        n_vec++; if (ram_addr_o !== 12'd0 || ram_data_o !== 64'd0 || ram_memwid_o !== 3'd0) begin
            n_err++; $display("FAIL rst_ram got addr %h data %h wid %0d want all 0", ram_addr_o, ram_data_o, ram_memwid_o); end
        req_valid_i = 0;
        rst = 0;
        @(negedge clk);
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", req_ready_o); end
    endtask

    task automatic test_store_load_d();
        txn(1, 64'h40, 64'h1122334455667788, 3'd3);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL sd_latency got %0d want 3", lat); end
        n_vec++; if (acc != 1 || mode_seen !== 2'd2 || addr_seen !== 12'd8) begin
            n_err++; $display("FAIL sd_access got n=%0d mode=%0d addr=%0d want n=1 mode=2 addr=8", acc, mode_seen, addr_seen); end
        n_vec++; if (resp_err_o !== 2'd0 || resp_rdata_o !== 64'd0) begin
            n_err++; $display("FAIL sd_resp got err=%0d rdata=%h want 0/0", resp_err_o, resp_rdata_o); end
        finish_resp();
        n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL sd_valid_drop got %0b want 0", resp_valid_o); end
        n_vec++; if (mem[8] !== 64'h1122334455667788) begin n_err++; $display("FAIL sd_mem got %h want 1122334455667788", mem[8]); end
        txn(0, 64'h40, 64'd0, 3'd3);
        n_vec++; if (lat != 3) begin n_err++; $display("FAIL ld_latency got %0d want 3", lat); end
        n_vec++; if (acc != 1 || mode_seen !== 2'd1 || addr_seen !== 12'd8) begin
            n_err++; $display("FAIL ld_access got n=%0d mode=%0d addr=%0d want n=1 mode=1 addr=8", acc, mode_seen, addr_seen); end
        n_vec++; if (resp_rdata_o !== 64'h1122334455667788 || resp_err_o !== 2'd0) begin
            n_err++; $display("FAIL ld_resp got rdata=%h err=%0d want 1122334455667788/0", resp_rdata_o, resp_err_o); end
        finish_resp();
    endtask

    task automatic test_byte();
        txn(1, 64'h10, 64'h80, 3'd0);
        finish_resp();
        txn(0, 64'h10, 64'd0, 3'd0);
        n_vec++; if (resp_rdata_o !== 64'hFFFFFFFFFFFFFF80) begin n_err++; $display("FAIL lb got %h want ffffffffffffff80", resp_rdata_o); end
        finish_resp();
        txn(0, 64'h10, 64'd0, 3'd4);
        n_vec++; if (resp_rdata_o !== 64'h80) begin n_err++; $display("FAIL lbu got %h want 80", resp_rdata_o); end
        finish_resp();
    endtask

    task automatic test_errors();
        logic        we_t  [6] = '{0, 0, 1, 0, 0, 0};
        logic [63:0] adr_t [6] = '{64'h12, 64'h8000, 64'h40, 64'h40, 64'h13, 64'h8001};
        logic [2:0]  wid_t [6] = '{3'd2, 3'd3, 3'd5, 3'd7, 3'd7, 3'd3};
        logic [1:0]  exp_t [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1};
        for (int i = 0; i < 6; i++) begin
            txn(we_t[i], adr_t[i], 64'hDEADBEEFCAFEF00D, wid_t[i]);
            n_vec++; if (resp_err_o !== exp_t[i] || resp_rdata_o !== 64'd0) begin
                n_err++; $display("FAIL err_case%0d got err=%0d rdata=%h want err=%0d rdata=0", i, resp_err_o, resp_rdata_o, exp_t[i]); end
            n_vec++; if (lat != 1 || acc != 0) begin
                n_err++; $display("FAIL err_timing%0d got lat=%0d accesses=%0d want lat=1 accesses=0", i, lat, acc); end
            finish_resp();
        end
    endtask

    task automatic test_ram_illegal();
        ram_illegal_i = 1;
        txn(0, 64'h40, 64'd0, 3'd3);
        ram_illegal_i = 0;
        n_vec++; if (lat != 3 || resp_err_o !== 2'd3 || resp_rdata_o !== 64'd0) begin
            n_err++; $display("FAIL ram_illegal got lat=%0d err=%0d rdata=%h want 3/3/0", lat, resp_err_o, resp_rdata_o); end
        finish_resp();
    endtask

    task automatic test_stall();
        txn(0, 64'h40, 64'd0, 3'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_vec++; if (resp_valid_o !== 1'b1 || resp_rdata_o !== 64'h1122334455667788 || resp_err_o !== 2'd0 || req_ready_o !== 1'b0) begin
                n_err++; $display("FAIL stall%0d got v=%0b rdata=%h err=%0d rdy=%0b want 1/1122334455667788/0/0",
                                  i, resp_valid_o, resp_rdata_o, resp_err_o, req_ready_o); end
        end
        finish_resp();
        n_vec++; if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            n_err++; $display("FAIL stall_release got v=%0b rdy=%0b want 0/1", resp_valid_o, req_ready_o); end
    endtask

    task automatic test_back_to_back(input logic [63:0] addr, input int exp_acc);
        int n = 0;
        int both = 0;
        @(negedge clk);
        resp_ready_i = 1; req_valid_i = 1; req_we_i = 0; req_addr_i = addr; req_memwid_i = 3'd3;
        for (int i = 0; i < 8; i++) begin
            if (req_ready_o) n++;
            if (req_ready_o && resp_valid_o) both++;
            @(negedge clk);
        end
        req_valid_i = 0;
        for (int i = 0; i < 10 && !(req_ready_o && !resp_valid_o); i++) @(negedge clk);
        resp_ready_i = 0;
        n_vec++; if (n != exp_acc) begin n_err++; $display("FAIL b2b_accepts addr=%h got %0d want %0d", addr, n, exp_acc); end
        n_vec++; if (both != 0) begin n_err++; $display("FAIL b2b_overlap got %0d want 0", both); end
    endtask

    task automatic test_reset_issue();
        @(negedge clk);
        req_valid_i = 1; req_we_i = 1; req_addr_i = 64'h40; req_wdata_i = 64'hA5A5A5A5A5A5A5A5; req_memwid_i = 3'd3;
        @(negedge clk);
        req_valid_i = 0;
        n_vec++; if (ram_access_mode_o !== 2'd2) begin n_err++; $display("FAIL rsti_issue got mode %0d want 2", ram_access_mode_o); end
        rst = 1;
        #1;
        n_vec++; if (ram_access_mode_o !== 2'd0) begin n_err++; $display("FAIL rsti_mode got %0d want 0", ram_access_mode_o); end
        @(negedge clk);
        rst = 0;
        n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rsti_ready got %0b want 1", req_ready_o); end
        resp_ready_i = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL rsti_noresp%0d got %0b want 0", i, resp_valid_o); end
        end
        n_vec++; if (mem[8] !== 64'h1122334455667788) begin n_err++; $display("FAIL rsti_mem got %h want 1122334455667788", mem[8]); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
        test_reset();
        test_store_load_d();
        test_byte();
        test_errors();
        test_ram_illegal();
        test_stall();
        test_back_to_back(64'h40, 2);
        test_back_to_back(64'h41, 4);
        test_reset_issue();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data word width in bits.
REQ-002 Parameter RAM_SIZE, default 12, RAM word-address width; RAM depth is 2**RAM_SIZE words.
REQ-003 Parameter ADDR_WIDTH, default 64, byte-address width of pipeline requests.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 req_valid_i  in  1  pipeline request valid.
REQ-008 req_ready_o  out  1  request accepted when req_valid_i and req_ready_o are both high at a rising edge.
REQ-009 req_we_i  in  1  1 = store, 0 = load.
REQ-010 req_addr_i  in  ADDR_WIDTH  byte address.
REQ-011 req_wdata_i  in  DATA_WIDTH  store data.
REQ-012 req_memwid_i  in  3  width code: B=000, H=001, W=010, D=011, BU=100, HU=101, WU=110; 111 is reserved.
REQ-013 resp_valid_o  out  1  response valid.
REQ-014 resp_ready_i  in  1  response consumed when resp_valid_o and resp_ready_i are both high at a rising edge.
REQ-015 resp_rdata_o  out  DATA_WIDTH  load result; 0 for stores and errors.
REQ-016 resp_err_o  out  2  error code: 0 none, 1 misaligned, 2 out of range, 3 illegal width/op.
REQ-017 ram_addr_o  out  RAM_SIZE  RAM word address.
REQ-018 ram_access_mode_o  out  2  0 NONE, 1 READ, 2 WRITE.
REQ-019 ram_data_o  out  DATA_WIDTH  RAM write data.
REQ-020 ram_memwid_o  out  3  RAM width code.
REQ-021 ram_data_i  in  DATA_WIDTH  RAM registered read data.
REQ-022 ram_illegal_i  in  1  RAM illegal-access flag.

Function
REQ-023 FSM states SHALL be IDLE, ISSUE, CAPTURE and RESP; req_ready_o is high only in IDLE.
REQ-024 On acceptance, the request SHALL be checked in the following priority order; the first failing check sets the error code:
- memwid 111, or a store with BU/HU/WU -> err 3
- req_addr_i[2:0] != 0 -> err 1
- req_addr_i[ADDR_WIDTH-1:RAM_SIZE+3] != 0 -> err 2
REQ-025 On an error, the FSM SHALL go IDLE->RESP with resp_rdata_o = 0, and ram_access_mode_o SHALL remain NONE (no RAM access).
REQ-026 On a legal request, the FSM SHALL go IDLE->ISSUE, and all ram_* outputs SHALL be registered at the accept edge.
- ram_addr_o = req_addr_i[RAM_SIZE+2:3].
- ram_memwid_o = req_memwid_i.
- ram_data_o = req_wdata_i.
- ram_access_mode_o = WRITE if req_we_i, else READ.
REQ-027 ISSUE SHALL last exactly one cycle, with ram_access_mode_o non-NONE only in that cycle; at its end the mode returns to NONE and the FSM moves to CAPTURE.
REQ-028 If ram_illegal_i is high during ISSUE, the block SHALL latch err 3 for this transaction.
REQ-029 In CAPTURE, the block SHALL register ram_data_i into resp_rdata_o for a load, or 0 for a store or on a latched error, then go to RESP.
REQ-030 A legal request SHALL produce resp_valid_o 3 cycles after the accept edge; an error request SHALL produce it 1 cycle after.
REQ-031 In RESP, resp_valid_o SHALL be 1 and resp_rdata_o/resp_err_o SHALL hold stable until the handshake; on the handshake the FSM goes to IDLE, and resp_valid_o SHALL be 0 in the next cycle.
REQ-032 A new request SHALL NOT be accepted in the same cycle as a response handshake; back-to-back throughput is 1 request per 4 cycles (legal) or 2 cycles (error).
REQ-033 The block SHALL perform no sign/zero extension; extension is owned by the RAM.

Reset
REQ-034 On rst assertion, asynchronously and regardless of state:
- state = IDLE
- req_ready_o = 1 once rst deasserts
- resp_valid_o = 0, resp_rdata_o = 0, resp_err_o = 0
- ram_access_mode_o = NONE, ram_addr_o = 0, ram_data_o = 0, ram_memwid_o = 0
REQ-035 Reset during ISSUE SHALL drop ram_access_mode_o to NONE immediately; the in-flight transaction SHALL be discarded with no response.

Verification
REQ-036 Store D to addr 0x40 with data 0x1122334455667788, then load D from 0x40 -> RAM word 8 is written; load resp_rdata_o = 0x1122334455667788, err 0, resp_valid_o 3 cycles after accept.
REQ-037 Store B 0x80 to 0x10, then load B and BU from 0x10 -> resp_rdata_o = 0xFFFFFFFFFFFFFF80 (B) and 0x80 (BU).
REQ-038 Error cases, each checked for no RAM access and resp_valid_o 1 cycle after accept:
- load W from 0x12 -> err 1
- load from 0x8000 with RAM_SIZE=12 -> err 2
- store HU -> err 3
- memwid 111 -> err 3
REQ-039 Hold resp_ready_i low 5 cycles in RESP -> resp_valid_o, resp_rdata_o and resp_err_o stay stable; req_ready_o = 0 throughout.
REQ-040 Assert rst during ISSUE of a store D to 0x40 -> ram_access_mode_o = NONE at once; no response; req_ready_o = 1 after rst deasserts.
